// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keyboard receiver.
//   rx_state_t     : receiver state encoding (IDLE, RX, CHECK)
//   PREFIX_EXT/REL : E0 (extended) and F0 (release) prefix bytes
//   IGNORED_CODES  : bytes that produce no key event and clear the prefix flags
//   is_ignored()   : membership test against IGNORED_CODES
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RX    = 2'd1,
        ST_CHECK = 2'd2
    } rx_state_t;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_REL = 8'hF0;

    localparam int NUM_IGNORED = 7;
    // Keyboard status/ack bytes that must never be reported as keys.
    localparam logic [8*NUM_IGNORED-1:0] IGNORED_CODES =
        {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

    function automatic logic is_ignored(input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_IGNORED; i++) begin
            if (IGNORED_CODES[i*8 +: 8] == code) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter -- 2-FF synchronizer plus debounce filter for one PS/2 line.
//   clk_sys : system clock
//   reset   : synchronous active-high reset (level returns to idle-high)
//   line    : raw asynchronous line
//   level   : filtered level; follows the line only after FILTER consecutive
//             synchronized samples that differ from the current level
//   fall    : one-cycle pulse, high in the same cycle level first reads 0
module ps2_line_filter #(
    parameter int FILTER = 4
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = (FILTER < 2) ? 1 : $clog2(FILTER + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          fall_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            fall_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= line;
            sync2_reg <= sync1_reg;
            fall_reg  <= 1'b0;
            if (sync2_reg == level_reg) begin
                // Any sample agreeing with the current level restarts the run.
                cnt_reg <= '0;
            end else if (cnt_reg == CW'(FILTER - 1)) begin
                level_reg <= sync2_reg;
                fall_reg  <= level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign level = level_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/ps2_key_gen.sv
// ps2_key_gen -- PS/2 keyboard frame receiver and key event generator.
//   clk_sys   : system clock, all logic on its rising edge
//   reset     : synchronous active-high reset
//   ps2_clk   : raw PS/2 clock line (asynchronous, idle high)
//   ps2_data  : raw PS/2 data line (asynchronous, idle high)
//   ps2_key   : [10] toggles per event, [9] make, [8] extended, [7:0] scan code
//   frame_err : one-cycle pulse when a frame is discarded (bad parity/stop
//               bit or mid-frame inactivity timeout)
module ps2_key_gen
    import ps2_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int TIMEOUT_US = 100,
    parameter int FILTER     = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    // 64-bit product: the default parameters overflow 32-bit arithmetic.
    localparam longint TMO_CYC_L = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 64'd1000000;
    localparam int     TMO_CYC   = int'(TMO_CYC_L);
    localparam int     TW        = $clog2(TMO_CYC + 1);

    logic raw_line   [2];
    logic filt_level [2];
    logic filt_fall  [2];

    assign raw_line[0] = ps2_clk;
    assign raw_line[1] = ps2_data;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_line
            ps2_line_filter #(
                .FILTER (FILTER)
            ) u_filter (
                .clk_sys (clk_sys),
                .reset   (reset),
                .line    (raw_line[gi]),
                .level   (filt_level[gi]),
                .fall    (filt_fall[gi])
            );
        end
    endgenerate

    logic clk_fall;
    logic data_level;
    logic data_fall_unused;

    assign clk_fall         = filt_fall[0];
    assign data_level       = filt_level[1];
    assign data_fall_unused = filt_fall[1] | filt_level[0];

    rx_state_t      state_reg;
    logic [3:0]     bit_cnt_reg;
    logic [8:0]     shift_reg;     // {parity, data[7:0]} once all bits are in
    logic [7:0]     byte_reg;
    logic           frame_ok_reg;
    logic           ext_reg;
    logic           rel_reg;
    logic [TW-1:0]  tmo_cnt_reg;
    logic [10:0]    key_reg;
    logic           frame_err_reg;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            byte_reg      <= '0;
            frame_ok_reg  <= 1'b0;
            ext_reg       <= 1'b0;
            rel_reg       <= 1'b0;
            tmo_cnt_reg   <= '0;
            key_reg       <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tmo_cnt_reg <= '0;
                    if (clk_fall && !data_level) begin
                        state_reg   <= ST_RX;
                        bit_cnt_reg <= 4'd1;
                        shift_reg   <= '0;
                    end
                end
                ST_RX: begin
                    // An edge always wins over an expiring timeout.
                    if (clk_fall) begin
                        tmo_cnt_reg <= '0;
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd10) begin
                            // This sample is the stop bit: judge the frame now so
                            // frame_err lines up with the CHECK cycle.
                            state_reg     <= ST_CHECK;
                            byte_reg      <= shift_reg[7:0];
                            frame_ok_reg  <= (^shift_reg) & data_level;
                            frame_err_reg <= ~((^shift_reg) & data_level);
                        end else begin
                            shift_reg <= {data_level, shift_reg[8:1]};
                        end
                    end else if (tmo_cnt_reg == TW'(TMO_CYC - 1)) begin
                        state_reg     <= ST_IDLE;
                        bit_cnt_reg   <= '0;
                        tmo_cnt_reg   <= '0;
                        frame_err_reg <= 1'b1;
                        ext_reg       <= 1'b0;
                        rel_reg       <= 1'b0;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_CHECK: begin
                    state_reg   <= ST_IDLE;
                    bit_cnt_reg <= '0;
                    if (!frame_ok_reg) begin
                        ext_reg <= 1'b0;
                        rel_reg <= 1'b0;
                    end else if (byte_reg == PREFIX_EXT) begin
                        ext_reg <= 1'b1;
                    end else if (byte_reg == PREFIX_REL) begin
                        rel_reg <= 1'b1;
                    end else if (is_ignored(byte_reg)) begin
                        ext_reg <= 1'b0;
                        rel_reg <= 1'b0;
                    end else begin
                        key_reg <= {~key_reg[10], ~rel_reg, ext_reg, byte_reg};
                        ext_reg <= 1'b0;
                        rel_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign ps2_key   = key_reg;
    assign frame_err = frame_err_reg;

endmodule
